// File: rtl/gray_step_monitor_if.sv
// Bundle between a Gray-counter source and gray_step_monitor:
// the Gray count going in, the decoded value and step pulses coming back.
interface gray_step_monitor_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] gray_in;
    logic [N-1:0] bin_out;
    logic         valid;
    logic         step_up;
    logic         step_down;
    logic         step_err;
    logic         wrap;
    logic [7:0]   err_cnt;

    modport master (
        output gray_in,
        input  bin_out, valid, step_up, step_down, step_err, wrap, err_cnt
    );

    modport slave (
        input  gray_in,
        output bin_out, valid, step_up, step_down, step_err, wrap, err_cnt
    );
endinterface

// File: rtl/gray_step_monitor.sv
// Synchronizes an asynchronous Gray count, decodes it and classifies every step.
// GRAY_STEP_MONITOR_ERRCNT_EN builds the saturating step_err counter; otherwise err_cnt is tied to 0.
module gray_step_monitor #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_step_monitor_if.slave   mon
);

    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [N-1:0]     sync_q [SYNC_STAGES];
    logic [N-1:0]     dec;
    logic [N-1:0]     diff;

    logic [N-1:0]     bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    // Synchronizer chain; only the final stage feeds the decoder
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= mon.gray_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Gray to binary: each bit is the XOR of all Gray bits at or above it
    always_comb begin
        dec = sync_q[SYNC_STAGES-1];
        for (int i = int'(N) - 2; i >= 0; i--) dec[i] = dec[i+1] ^ sync_q[SYNC_STAGES-1][i];
    end

    assign diff = dec - bin_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // Next state: FILL waits for the synchronizer to hold post-reset samples
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        case (state_q)
            FILL: begin
                if (fill_cnt_q == CNT_W'(SYNC_STAGES - 1)) state_d = PRIME;
                else fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
            PRIME:   state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = FILL;
        endcase
    end

    // Output next values; PRIME takes the reference sample without pulsing
    always_comb begin
        bin_d   = bin_q;
        valid_d = valid_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            FILL: valid_d = 1'b0;
            PRIME: begin
                bin_d   = dec;
                valid_d = 1'b1;
            end
            TRACK: begin
                bin_d = dec;
                if (diff == N'(1)) begin
                    up_d   = 1'b1;
                    wrap_d = (bin_q == {N{1'b1}});
                end else if (diff == {N{1'b1}}) begin
                    down_d = 1'b1;
                    wrap_d = (bin_q == '0);
                end else if (diff != '0) begin
                    err_d = 1'b1;
                end
            end
            default: valid_d = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            valid_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            valid_q <= valid_d;
            up_q    <= up_d;
            down_q  <= down_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign mon.bin_out   = bin_q;
    assign mon.valid     = valid_q;
    assign mon.step_up   = up_q;
    assign mon.step_down = down_q;
    assign mon.step_err  = err_q;
    assign mon.wrap      = wrap_q;

`ifdef GRAY_STEP_MONITOR_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturates at 255 so a burst of errors never reads back as "clean"
    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= 8'd0;
        else if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign mon.err_cnt = err_cnt_q;
`else
    assign mon.err_cnt = 8'd0;
`endif

endmodule
